// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
//
// Responder side of a 3x3 matrix keypad scan interface. A request asks for
// key K to be pressed for H clock cycles. The emulator plays out the contact
// profile of a real key: make-bounce, solid hold, break-bounce, and a
// completion pulse. The closed contact is reflected onto the active-low row
// lines whenever the scanner strobes the key's column.
//
// Parameters
//   BOUNCE_CYCLES : clk cycles of bounce on make and on break (0 = no bounce)
//   BOUNCE_PERIOD : clk cycles per contact toggle while bouncing (>= 1)
//   HOLD_W        : width of the hold_cycles request field
//
// Ports
//   clk          in   system clock, rising edge
//   clear        in   asynchronous active-low reset
//   column[2:0]  in   column strobes from scanner, active-low
//   press_valid  in   press request valid
//   press_key    in   key code: [3:2] column 0..2, [1:0] row 0..2
//   hold_cycles  in   solid-contact duration (0 behaves as 1)
//   press_ready  out  request can be accepted (registered)
//   row[2:0]     out  row lines to scanner, active-low (combinational)
//   busy         out  press sequence in progress (registered)
//   done         out  one-cycle pulse while the sequence completes (registered)
//   err_invalid  out  one-cycle pulse after an invalid code is rejected
// ---------------------------------------------------------------------------
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 8,
    parameter int BOUNCE_PERIOD = 2,
    parameter int HOLD_W        = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [2:0]        column,
    input  logic              press_valid,
    input  logic [3:0]        press_key,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              press_ready,
    output logic [2:0]        row,
    output logic              busy,
    output logic              done,
    output logic              err_invalid
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_BOUNCE_IN  = 3'd1;
    localparam logic [2:0] ST_HOLD       = 3'd2;
    localparam logic [2:0] ST_BOUNCE_OUT = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    // Counter widths only need to reach the last index, never the count itself.
    localparam int BCW = (BOUNCE_CYCLES < 2) ? 1 : $clog2(BOUNCE_CYCLES);
    localparam int PCW = (BOUNCE_PERIOD < 2) ? 1 : $clog2(BOUNCE_PERIOD);

    localparam logic [BCW-1:0] BOUNCE_LAST = BCW'(BOUNCE_CYCLES - 1);
    localparam logic [PCW-1:0] PERIOD_LAST = PCW'(BOUNCE_PERIOD - 1);
    localparam bit             SKIP_BOUNCE = (BOUNCE_CYCLES == 0);

    // A code is invalid when either index selects the non-existent 4th line.
    function automatic logic key_is_invalid(input logic [3:0] key);
        return (key[3:2] == 2'b11) || (key[1:0] == 2'b11);
    endfunction

    // Registered state
    logic [2:0]        state_r;
    logic [BCW-1:0]    bcnt_r;
    logic [PCW-1:0]    pcnt_r;
    logic              phase_r;
    logic [HOLD_W-1:0] hcnt_r;
    logic [HOLD_W-1:0] hold_r;
    logic [1:0]        key_col_r;
    logic [1:0]        key_row_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    // Next-state values
    logic [2:0]        state_s;
    logic [BCW-1:0]    bcnt_s;
    logic [PCW-1:0]    pcnt_s;
    logic              phase_s;
    logic [HOLD_W-1:0] hcnt_s;
    logic [HOLD_W-1:0] hold_s;
    logic [1:0]        key_col_s;
    logic [1:0]        key_row_s;
    logic              err_s;

    // Bounce phase bookkeeping: phase flips every BOUNCE_PERIOD cycles so
    // phase_r equals the parity of floor(b / BOUNCE_PERIOD).
    logic [PCW-1:0]    pcnt_adv_s;
    logic              phase_adv_s;

    // Contact and column-match helpers for row generation
    logic              contact_s;
    logic              col_sel_s;

    // Advance of the bounce phase counter by one cycle.
    always_comb begin
        pcnt_adv_s  = pcnt_r;
        phase_adv_s = phase_r;
        if (pcnt_r == PERIOD_LAST) begin
            pcnt_adv_s  = {PCW{1'b0}};
            phase_adv_s = ~phase_r;
        end else begin
            pcnt_adv_s  = pcnt_r + PCW'(1);
            phase_adv_s = phase_r;
        end
    end

    // Press sequencer next-state logic.
    always_comb begin
        state_s   = state_r;
        bcnt_s    = bcnt_r;
        pcnt_s    = pcnt_r;
        phase_s   = phase_r;
        hcnt_s    = hcnt_r;
        hold_s    = hold_r;
        key_col_s = key_col_r;
        key_row_s = key_row_r;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bcnt_s  = {BCW{1'b0}};
                pcnt_s  = {PCW{1'b0}};
                phase_s = 1'b0;
                hcnt_s  = {HOLD_W{1'b0}};
                if (press_valid && ready_r) begin
                    if (key_is_invalid(press_key)) begin
                        err_s = 1'b1;
                    end else begin
                        key_col_s = press_key[3:2];
                        key_row_s = press_key[1:0];
                        hold_s    = (hold_cycles == {HOLD_W{1'b0}}) ? HOLD_W'(1) : hold_cycles;
                        state_s   = SKIP_BOUNCE ? ST_HOLD : ST_BOUNCE_IN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BOUNCE_IN: begin
                if (bcnt_r == BOUNCE_LAST) begin
                    state_s = ST_HOLD;
                    bcnt_s  = {BCW{1'b0}};
                    pcnt_s  = {PCW{1'b0}};
                    phase_s = 1'b0;
                end else begin
                    bcnt_s  = bcnt_r + BCW'(1);
                    pcnt_s  = pcnt_adv_s;
                    phase_s = phase_adv_s;
                end
            end
            ST_HOLD: begin
                // hold_r is never zero here, so hold_r-1 is the last index.
                if (hcnt_r == (hold_r - HOLD_W'(1))) begin
                    hcnt_s  = {HOLD_W{1'b0}};
                    state_s = SKIP_BOUNCE ? ST_DONE : ST_BOUNCE_OUT;
                end else begin
                    hcnt_s  = hcnt_r + HOLD_W'(1);
                end
            end
            ST_BOUNCE_OUT: begin
                if (bcnt_r == BOUNCE_LAST) begin
                    state_s = ST_DONE;
                    bcnt_s  = {BCW{1'b0}};
                    pcnt_s  = {PCW{1'b0}};
                    phase_s = 1'b0;
                end else begin
                    bcnt_s  = bcnt_r + BCW'(1);
                    pcnt_s  = pcnt_adv_s;
                    phase_s = phase_adv_s;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                bcnt_s  = {BCW{1'b0}};
                pcnt_s  = {PCW{1'b0}};
                phase_s = 1'b0;
                hcnt_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State, counters, latched request and registered status outputs.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r   <= ST_IDLE;
            bcnt_r    <= {BCW{1'b0}};
            pcnt_r    <= {PCW{1'b0}};
            phase_r   <= 1'b0;
            hcnt_r    <= {HOLD_W{1'b0}};
            hold_r    <= {HOLD_W{1'b0}};
            key_col_r <= 2'd0;
            key_row_r <= 2'd0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            bcnt_r    <= bcnt_s;
            pcnt_r    <= pcnt_s;
            phase_r   <= phase_s;
            hcnt_r    <= hcnt_s;
            hold_r    <= hold_s;
            key_col_r <= key_col_s;
            key_row_r <= key_row_s;
            ready_r   <= (state_s == ST_IDLE);
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_DONE);
            err_r     <= err_s;
        end
    end

    // Contact closure implied by the current phase: make-bounce starts
    // closed, break-bounce starts open.
    always_comb begin
        contact_s = 1'b0;
        case (state_r)
            ST_BOUNCE_IN:  contact_s = ~phase_r;
            ST_HOLD:       contact_s = 1'b1;
            ST_BOUNCE_OUT: contact_s = phase_r;
            default:       contact_s = 1'b0;
        endcase
    end

    // The key's column is strobed when its active-low line is low; other
    // columns being low at the same time does not matter.
    always_comb begin
        col_sel_s = 1'b0;
        case (key_col_r)
            2'd0:    col_sel_s = ~column[0];
            2'd1:    col_sel_s = ~column[1];
            2'd2:    col_sel_s = ~column[2];
            default: col_sel_s = 1'b0;
        endcase
    end

    // Row drive: pull the key's row low only while contact is closed and
    // its column is strobed.
    always_comb begin
        row = 3'b111;
        if (contact_s && col_sel_s) begin
            case (key_row_r)
                2'd0:    row = 3'b110;
                2'd1:    row = 3'b101;
                2'd2:    row = 3'b011;
                default: row = 3'b111;
            endcase
        end else begin
            row = 3'b111;
        end
    end

    assign press_ready = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_invalid = err_r;

endmodule

// File: tb/tb_keypad_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_emulator
//
// Self-checking bench. A cycle-indexed reference model derives the expected
// contact profile from plain arithmetic on the cycle number since acceptance.
// Directed sequences cover reset, the basic press waveform, column gating,
// invalid codes and a reset mid-hold; a second instance without bounce
// covers back-to-back requests. Randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_keypad_emulator;

    localparam int BC = 8;
    localparam int BP = 2;
    localparam int HW = 16;

    logic          clk = 1'b0;
    logic          clear;
    logic [2:0]    column;
    logic          press_valid;
    logic [3:0]    press_key;
    logic [HW-1:0] hold_cycles;
    logic          press_ready;
    logic [2:0]    row;
    logic          busy;
    logic          done;
    logic          err_invalid;

    logic [2:0]    column0;
    logic          valid0;
    logic [3:0]    key0;
    logic [HW-1:0] hold0;
    logic          ready0;
    logic [2:0]    row0;
    logic          busy0;
    logic          done0;
    logic          err0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: m_k = cycle index since acceptance, 0 = idle.
    int m_k   = 0;
    int m_len = 0;
    int m_hm  = 1;
    int m_col = 0;
    int m_row = 0;
    bit m_err = 1'b0;

    keypad_emulator #(.BOUNCE_CYCLES(BC), .BOUNCE_PERIOD(BP), .HOLD_W(HW)) dut (
        .clk(clk), .clear(clear), .column(column), .press_valid(press_valid),
        .press_key(press_key), .hold_cycles(hold_cycles), .press_ready(press_ready),
        .row(row), .busy(busy), .done(done), .err_invalid(err_invalid)
    );

    keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_PERIOD(BP), .HOLD_W(HW)) dut0 (
        .clk(clk), .clear(clear), .column(column0), .press_valid(valid0),
        .press_key(key0), .hold_cycles(hold0), .press_ready(ready0),
        .row(row0), .busy(busy0), .done(done0), .err_invalid(err0)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Contact level at cycle k of a press sequence.
    function automatic bit model_contact(input int k);
        if (k < 1)                   return 1'b0;
        if (k <= BC)                 return (((k - 1) / BP) % 2) == 0;
        if (k <= BC + m_hm)          return 1'b1;
        if (k <= 2 * BC + m_hm)      return (((k - 1 - BC - m_hm) / BP) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] model_row();
        logic [2:0] r;
        r = 3'b111;
        if (model_contact(m_k) && column[m_col] == 1'b0) r[m_row] = 1'b0;
        return r;
    endfunction

    task automatic compare_all();
        check_eq("row",   32'(row),         32'(model_row()));
        check_eq("ready", 32'(press_ready), 32'(m_k == 0));
        check_eq("busy",  32'(busy),        32'(m_k != 0));
        check_eq("done",  32'(done),        32'(m_k != 0 && m_k == m_len));
        check_eq("err",   32'(err_invalid), 32'(m_err));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic cycle();
        @(posedge clk);
        m_err = 1'b0;
        if (!clear) begin
            m_k = 0;
        end else if (m_k == 0) begin
            if (press_valid) begin
                if (press_key[3:2] == 2'd3 || press_key[1:0] == 2'd3) begin
                    m_err = 1'b1;
                end else begin
                    m_col = int'(press_key[3:2]);
                    m_row = int'(press_key[1:0]);
                    m_hm  = (hold_cycles == 0) ? 1 : int'(hold_cycles);
                    m_len = 2 * BC + m_hm + 1;
                    m_k   = 1;
                end
            end
        end else if (m_k == m_len) begin
            m_k = 0;
        end else begin
            m_k++;
        end
        #1;
        compare_all();
    endtask

    task automatic press(input logic [3:0] key, input int h);
        press_valid = 1'b1;
        press_key   = key;
        hold_cycles = HW'(h);
        cycle();
        press_valid = 1'b0;
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 600 && m_k != 0; i++) cycle();
        cycle();
        check_eq("idle_reached", 32'(press_ready), 32'd1);
    endtask

    logic [2:0] bin_rows [8];
    logic [2:0] bout_rows[8];
    logic [2:0] gate_cols[4];
    logic [2:0] gate_rows[4];
    logic [2:0] exp_r;

    initial begin
        bin_rows  = '{3'b101, 3'b101, 3'b111, 3'b111, 3'b101, 3'b101, 3'b111, 3'b111};
        bout_rows = '{3'b111, 3'b111, 3'b101, 3'b101, 3'b111, 3'b111, 3'b101, 3'b101};
        gate_cols = '{3'b110, 3'b101, 3'b011, 3'b000};
        gate_rows = '{3'b111, 3'b111, 3'b110, 3'b110};

        clear = 1'b0; column = 3'b111; press_valid = 1'b0; press_key = 4'd0; hold_cycles = '0;
        column0 = 3'b000; valid0 = 1'b0; key0 = 4'd0; hold0 = '0;
        #12;
        compare_all();
        check_eq("rst_row0",   32'(row0),   32'(3'b111));
        check_eq("rst_ready0", 32'(ready0), 32'd1);
        clear = 1'b1;
        repeat (3) cycle();

        // Basic press waveform on column 0, row 1.
        column = 3'b110;
        press(4'b0001, 10);
        for (int k = 1; k <= 28; k++) begin
            if (k > 1) cycle();
            if (k <= 8)       exp_r = bin_rows[k - 1];
            else if (k <= 18) exp_r = 3'b101;
            else if (k <= 26) exp_r = bout_rows[k - 19];
            else              exp_r = 3'b111;
            check_eq("basic_row", 32'(row), 32'(exp_r));
            if (k == 27) check_eq("basic_done", 32'(done), 32'd1);
            if (k == 28) check_eq("basic_ready", 32'(press_ready), 32'd1);
        end

        // Column gating during hold for col 2 / row 0.
        press(4'b1000, 40);
        while (m_k < 12) cycle();
        for (int i = 0; i < 4; i++) begin
            column = gate_cols[i];
            #1;
            check_eq("gate_row", 32'(row), 32'(gate_rows[i]));
        end
        column = 3'b110;
        run_until_idle();

        // Invalid code is rejected without starting a press.
        column = 3'b000;
        press(4'b0011, 5);
        check_eq("inv_err",  32'(err_invalid), 32'd1);
        check_eq("inv_busy", 32'(busy),        32'd0);
        check_eq("inv_row",  32'(row),         32'(3'b111));
        cycle();
        check_eq("inv_err_pulse", 32'(err_invalid), 32'd0);

        // Reset in the middle of a long hold.
        column = 3'b101;
        press(4'b0101, 100);
        while (m_k < 20) cycle();
        check_eq("mid_row_low", 32'(row), 32'(3'b101));
        #2;
        clear = 1'b0;
        #1;
        m_k = 0; m_err = 1'b0;
        compare_all();
        repeat (2) cycle();
        #2;
        clear = 1'b1;
        repeat (5) cycle();
        press(4'b0101, 3);
        check_eq("post_rst_busy", 32'(busy), 32'd1);
        run_until_idle();

        // Back-to-back requests on the no-bounce instance, valid held high.
        @(posedge clk); #1;
        valid0 = 1'b1; key0 = 4'b0000; hold0 = '0;
        @(posedge clk); #1;
        key0 = 4'b0110;
        #1;
        check_eq("b2b_row_first", 32'(row0),  32'(3'b110));
        check_eq("b2b_busy_first", 32'(busy0), 32'd1);
        check_eq("b2b_ready_first", 32'(ready0), 32'd0);
        @(posedge clk); #1;
        check_eq("b2b_done_first", 32'(done0), 32'd1);
        check_eq("b2b_row_done",   32'(row0),  32'(3'b111));
        @(posedge clk); #1;
        check_eq("b2b_ready_idle", 32'(ready0), 32'd1);
        check_eq("b2b_busy_idle",  32'(busy0),  32'd0);
        @(posedge clk); #1;
        check_eq("b2b_row_second", 32'(row0), 32'(3'b011));
        check_eq("b2b_busy_second", 32'(busy0), 32'd1);
        @(posedge clk); #1;
        check_eq("b2b_done_second", 32'(done0), 32'd1);
        valid0 = 1'b0;
        @(posedge clk); #1;
        check_eq("b2b_final_ready", 32'(ready0), 32'd1);

        // Randomized traffic with mid-cycle column changes.
        for (int i = 0; i < 1500; i++) begin
            press_valid = ($urandom_range(0, 3) == 0);
            press_key   = 4'($urandom_range(0, 15));
            hold_cycles = HW'($urandom_range(0, 10));
            column      = 3'($urandom_range(0, 7));
            cycle();
            column = 3'($urandom_range(0, 7));
            #1;
            check_eq("rand_row", 32'(row), 32'(model_row()));
        end
        press_valid = 1'b0;
        run_until_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Behavioural-but-synthesizable model of the 3x3 matrix keypad, i.e. the responder side of the keypad scan interface.
- Accepts "press key K for H cycles" requests and generates contact bounce on make and break.
- Drives active-low row lines in response to the active-low column strobes from the keypad scanner.
- Used on-FPGA and in benches to exercise the scanner, debouncer and key registers without physical keys.

Parameters:
BOUNCE_CYCLES, 8, clk cycles of bounce on both make and break; 0 skips the bounce phases
BOUNCE_PERIOD, 2, clk cycles per contact toggle during bounce; must be >= 1
HOLD_W, 16, width of the hold_cycles request field

Ports:
clk  input  1  system clock; all state changes on posedge
clear  input  1  asynchronous active-low reset
column  input  3  column strobes from scanner, active-low; column[c]==0 selects column c
press_valid  input  1  press request valid
press_key  input  4  key code: [3:2] column index 0..2, [1:0] row index 0..2
hold_cycles  input  HOLD_W  solid-contact duration in clk cycles
press_ready  output  1  high when a request can be accepted
row  output  3  row lines to scanner, active-low
busy  output  1  high while a press is in progress
done  output  1  one-cycle pulse when a press sequence completes
err_invalid  output  1  one-cycle pulse when an invalid key code is rejected

Behaviour:
- Reset (clear low, asynchronous): state IDLE, contact=0, all counters 0, row=3'b111, press_ready=1, busy=0, done=0, err_invalid=0. Asserting reset mid-press aborts immediately; row releases to 3'b111 with no done pulse.
- Handshake: a request is accepted on a posedge where press_valid && press_ready. press_key and hold_cycles are latched on acceptance. Inputs are ignored while press_ready=0.
- Invalid code: press_key[3:2]==3 or press_key[1:0]==3. Accepted, not executed. err_invalid=1 for the next cycle; state stays IDLE; press_ready stays 1.
- hold_cycles==0 is treated as 1.
- States: IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> DONE -> IDLE.
  - IDLE: contact=0, press_ready=1, busy=0. A valid accept at edge T enters BOUNCE_IN at T+1, or HOLD if BOUNCE_CYCLES==0.
  - BOUNCE_IN: lasts exactly BOUNCE_CYCLES cycles. Bounce count b runs 0..BOUNCE_CYCLES-1. contact=1 when floor(b/BOUNCE_PERIOD) is even, else 0; the first cycle is contact=1.
  - HOLD: contact=1 for exactly max(hold_cycles,1) cycles.
  - BOUNCE_OUT: lasts BOUNCE_CYCLES cycles. contact=0 when floor(b/BOUNCE_PERIOD) is even, else 1; the first cycle is contact=0.
  - DONE: one cycle, contact=0, done=1. Then IDLE.
- press_ready=0 and busy=1 in every state except IDLE.
- Row generation is combinational from column and registered state: row[r]=0 iff contact==1 && r==latched row index && column[latched col]==0; otherwise row[r]=1.
  - Multiple columns low: the row still responds if the key's column is among them.
  - column==3'b111: row=3'b111.
- Counters saturate/clear on state exit and never wrap within a state. The hold counter is HOLD_W bits wide and compares against the latched value.
- A new request can be accepted on the cycle IDLE is re-entered. Total busy time = 2*BOUNCE_CYCLES + max(H,1) + 1 cycles.

Test Plan:
- Reset mid-HOLD: press key 4'b0101, H=100; pull clear low at cycle 20 -> row=3'b111 within the same cycle; press_ready=1; no done pulse; a fresh press is accepted after clear releases.
- Basic press: defaults, column=3'b110 held; accept key 4'b0001, H=10 at edge T -> row sequence over cycles T+1..T+8 is 101,101,111,111,101,101,111,111; then 101 for 10 cycles; then 111,111,101,101,111,111,101,101; done=1 at T+27; press_ready=1 at T+28.
- Column gating: key 4'b1000 (col 2, row 0) in HOLD; sweep column 110, 101, 011, 000 -> row = 111, 111, 110, 110.
- Invalid code: press_key=4'b0011 -> err_invalid=1 for one cycle; busy stays 0; row=3'b111 throughout.
- Back-to-back and ignore-while-busy: press_valid held high with keys 4'b0000 then 4'b0110, H=0, BOUNCE_CYCLES=0 -> first key: contact 1 cycle, done, then second accepted the cycle IDLE is re-entered; requests during busy do not alter the latched key.
